// File: rtl/game_pkg.sv
// Shared game-level constants: the game_state encoding seen by the display and
// renderers, the sequencer's internal state set, and the BCD score width.
package game_pkg;

    localparam logic [1:0] GAME_INITIAL = 2'd0;
    localparam logic [1:0] GAME_PLAYING = 2'd1;
    localparam logic [1:0] GAME_OVER    = 2'd2;

    localparam int BCD_W = 16;

    typedef enum logic [2:0] {
        S_INIT,
        S_PLAY,
        S_LOCK,
        S_OVER,
        S_RESTART
    } fsm_state_t;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter that saturates at 9999, with a synchronous clear and
// a flag that marks an increment rolling x99 over to (x+1)00.
module bcd_counter4
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] count,
    output logic             hund_carry
);

    logic [BCD_W-1:0] count_inc;
    logic             carry;
    logic             sat;

    always_comb begin
        count_inc = count;
        carry     = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (count[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    assign sat        = (count == {4{4'd9}});
    assign hund_carry = en && !clr && !sat && (count[7:0] == 8'h99);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !sat) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Central game sequencer: button conditioning, run/lockout/restart FSM, score,
// high score and scroll-speed bookkeeping, all paced by the 100 Hz game tick.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int SPEED_INIT    = 3,
    parameter int SPEED_MAX     = 8,
    parameter int SCORE_DIV     = 10,
    parameter int LOCKOUT_TICKS = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_100Hz,
    input  logic             btn_raw,
    input  logic             collision,
    output logic [1:0]       game_state,
    output logic [BCD_W-1:0] score,
    output logic [BCD_W-1:0] high_score,
    output logic [3:0]       speed,
    output logic             btn_press
);

    localparam int DIV_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int LOCK_W = (LOCKOUT_TICKS > 1) ? $clog2(LOCKOUT_TICKS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCORE_DIV - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCKOUT_TICKS - 1);
    localparam logic [3:0]        SPEED_RST  = 4'(SPEED_INIT);
    localparam logic [3:0]        SPEED_TOP  = 4'(SPEED_MAX);

    fsm_state_t        state;
    logic              btn_sync1;
    logic              btn_sync2;
    logic              btn_prev;
    logic [DIV_W-1:0]  div_cnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic              score_en;
    logic              score_clr;
    logic              hund_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_sync1 <= 1'b0;
            btn_sync2 <= 1'b0;
            btn_prev  <= 1'b0;
            btn_press <= 1'b0;
        end else begin
            btn_sync1 <= btn_raw;
            btn_sync2 <= btn_sync1;
            btn_prev  <= btn_sync2;
            btn_press <= btn_sync2 && !btn_prev;
        end
    end

    // A colliding clk never scores, so the high-score compare sees the frozen value.
    assign score_en  = (state == S_PLAY) && tick_100Hz && !collision && (div_cnt == DIV_LAST);
    assign score_clr = ((state == S_INIT) && btn_press) || ((state == S_RESTART) && tick_100Hz);

    bcd_counter4 u_score (
        .clk        (clk),
        .rst        (rst),
        .clr        (score_clr),
        .en         (score_en),
        .count      (score),
        .hund_carry (hund_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INIT;
            game_state <= GAME_INITIAL;
            high_score <= '0;
            speed      <= SPEED_RST;
            div_cnt    <= '0;
            lock_cnt   <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (btn_press) begin
                        state      <= S_PLAY;
                        game_state <= GAME_PLAYING;
                        speed      <= SPEED_RST;
                        div_cnt    <= '0;
                    end
                end
                S_PLAY: begin
                    if (collision) begin
                        state      <= S_LOCK;
                        game_state <= GAME_OVER;
                        lock_cnt   <= '0;
                        if (score > high_score) begin
                            high_score <= score;
                        end
                    end else begin
                        if (tick_100Hz) begin
                            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
                        end
                        if (hund_carry && speed < SPEED_TOP) begin
                            speed <= speed + 4'd1;
                        end
                    end
                end
                S_LOCK: begin
                    if (tick_100Hz) begin
                        if (lock_cnt == LOCK_LAST) begin
                            state <= S_OVER;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
                end
                S_OVER: begin
                    if (btn_press) begin
                        state      <= S_RESTART;
                        game_state <= GAME_INITIAL;
                    end
                end
                S_RESTART: begin
                    // Held INITIAL until a tick so the display sees it at least once.
                    if (tick_100Hz) begin
                        state      <= S_PLAY;
                        game_state <= GAME_PLAYING;
                        speed      <= SPEED_RST;
                        div_cnt    <= '0;
                    end
                end
                default: begin
                    state      <= S_INIT;
                    game_state <= GAME_INITIAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a default-parameter instance for the game
// flow, plus a SCORE_DIV=1 instance driven in parallel to reach score saturation.
module tb_game_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_100Hz;
    logic        btn_raw;
    logic        collision;

    logic [1:0]  gs_a, gs_b;
    logic [15:0] score_a, score_b;
    logic [15:0] hs_a, hs_b;
    logic [3:0]  speed_a, speed_b;
    logic        bp_a, bp_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] max_speed_a = '0;
    logic [3:0] max_speed_b = '0;

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .SPEED_INIT    (3),
        .SPEED_MAX     (8),
        .SCORE_DIV     (10),
        .LOCKOUT_TICKS (50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_100Hz (tick_100Hz),
        .btn_raw    (btn_raw),
        .collision  (collision),
        .game_state (gs_a),
        .score      (score_a),
        .high_score (hs_a),
        .speed      (speed_a),
        .btn_press  (bp_a)
    );

    game_flow_ctrl #(
        .SPEED_INIT    (3),
        .SPEED_MAX     (8),
        .SCORE_DIV     (1),
        .LOCKOUT_TICKS (50)
    ) dut_fast (
        .clk        (clk),
        .rst        (rst),
        .tick_100Hz (tick_100Hz),
        .btn_raw    (btn_raw),
        .collision  (collision),
        .game_state (gs_b),
        .score      (score_b),
        .high_score (hs_b),
        .speed      (speed_b),
        .btn_press  (bp_b)
    );

    always @(negedge clk) begin
        if (speed_a > max_speed_a) max_speed_a = speed_a;
        if (speed_b > max_speed_b) max_speed_b = speed_b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            tick_100Hz = 1'b1;
            step(1);
            tick_100Hz = 1'b0;
            step(1);
        end
    endtask

    task automatic press_btn();
        btn_raw = 1'b1;
        step(4);
        btn_raw = 1'b0;
        step(4);
    endtask

    task automatic collide();
        collision = 1'b1;
        step(1);
        collision = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        tick_100Hz = 1'b0;
        btn_raw    = 1'b0;
        collision  = 1'b0;
        step(3);
        rst = 1'b0;
        check("rst_state",  gs_a,    2'd0);
        check("rst_score",  score_a, 16'h0000);
        check("rst_high",   hs_a,    16'h0000);
        check("rst_speed",  speed_a, 4'd3);
        check("rst_btn",    bp_a,    1'b0);
        check("rst_state_b", gs_b,   2'd0);

        // button edge: pulse visible after the third edge, FSM moves on the fourth
        btn_raw = 1'b1;
        step(1);
        check("bp_e1", bp_a, 1'b0);
        step(1);
        check("bp_e2", bp_a, 1'b0);
        step(1);
        check("bp_e3", bp_a, 1'b1);
        check("bp_e3_state", gs_a, 2'd0);
        step(1);
        check("bp_e4", bp_a, 1'b0);
        check("start_state", gs_a, 2'd1);
        check("start_bp_b", bp_b, 1'b0);
        step(1);
        btn_raw = 1'b0;
        step(4);
        check("bp_no_repeat", bp_a, 1'b0);
        check("start_score", score_a, 16'h0000);
        check("start_speed", speed_a, 4'd3);

        tick_n(990);
        check("score_99",  score_a, 16'h0099);
        check("speed_99",  speed_a, 4'd3);
        tick_n(10);
        check("score_100", score_a, 16'h0100);
        check("speed_100", speed_a, 4'd4);

        tick_n(230);
        check("score_123", score_a, 16'h0123);
        collide();
        check("coll1_state", gs_a, 2'd2);
        check("coll1_high",  hs_a, 16'h0123);

        // lockout: presses within the first 49 ticks are ignored
        tick_n(20);
        press_btn();
        check("lock_press20", gs_a, 2'd2);
        tick_n(29);
        press_btn();
        check("lock_press49", gs_a, 2'd2);
        tick_n(1);
        check("over_state", gs_a, 2'd2);
        press_btn();
        check("restart_state", gs_a, 2'd0);
        tick_n(1);
        check("run2_state", gs_a, 2'd1);
        check("run2_score", score_a, 16'h0000);
        check("run2_speed", speed_a, 4'd3);

        tick_n(500);
        check("score_50", score_a, 16'h0050);
        collide();
        check("coll2_state", gs_a, 2'd2);
        check("coll2_high",  hs_a, 16'h0123);

        tick_n(50);
        press_btn();
        tick_n(1);
        check("run3_state", gs_a, 2'd1);
        tick_n(2000);
        check("score_200", score_a, 16'h0200);
        check("speed_200", speed_a, 4'd5);
        collide();
        check("coll3_high", hs_a, 16'h0200);

        tick_n(50);
        press_btn();
        tick_n(1);
        tick_n(19);
        check("score_1", score_a, 16'h0001);
        // tick that would score coincides with collision
        tick_100Hz = 1'b1;
        collision  = 1'b1;
        step(1);
        tick_100Hz = 1'b0;
        collision  = 1'b0;
        check("simul_score", score_a, 16'h0001);
        check("simul_state", gs_a, 2'd2);
        check("simul_high",  hs_a, 16'h0200);
        step(1);
        // entry tick did not count: after 49 more ticks still locked
        tick_n(49);
        press_btn();
        check("entry_tick_lock", gs_a, 2'd2);
        tick_n(1);
        press_btn();
        check("entry_tick_over", gs_a, 2'd0);
        tick_n(1);
        tick_n(30);
        check("run5_score", score_a, 16'h0003);
        check("run5_state", gs_a, 2'd1);

        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_state", gs_a, 2'd0);
        check("mid_rst_score", score_a, 16'h0000);
        check("mid_rst_high",  hs_a, 16'h0000);
        check("mid_rst_speed", speed_a, 4'd3);
        check("mid_rst_high_b", hs_b, 16'h0000);

        press_btn();
        check("sat_start_a", gs_a, 2'd1);
        check("sat_start_b", gs_b, 2'd1);
        tick_n(10005);
        check("sat_score_a", score_a, 16'h1000);
        check("sat_speed_a", speed_a, 4'd8);
        check("sat_score_b", score_b, 16'h9999);
        check("sat_speed_b", speed_b, 4'd8);
        check("max_speed_a", {31'd0, max_speed_a > 4'd8}, 32'd0);
        check("max_speed_b", {31'd0, max_speed_b > 4'd8}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
